// File: rtl/matmul_pkg.sv
// Shared types and default sizing for the systolic matmul engine output stage.
package matmul_pkg;

    localparam int unsigned ROWS_DFLT               = 4;
    localparam int unsigned COLS_DFLT               = 4;
    localparam int unsigned WORD_SIZE_DFLT          = 16;
    localparam int unsigned MEM_PORT_WIDTH_DFLT     = 64;
    localparam int unsigned MEM_ACCESS_LATENCY_DFLT = 1;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        WRITE,
        WAIT,
        DONE
    } state_t;

    typedef logic [WORD_SIZE_DFLT-1:0] word_t;

endpackage

// File: rtl/matmul_out_ctrl_if.sv
// Upstream result/handshake signals and output RAM write port of the output stage.
interface matmul_out_ctrl_if
    import matmul_pkg::*;
#(
    parameter int unsigned COLS           = COLS_DFLT,
    parameter int unsigned WORD_SIZE      = WORD_SIZE_DFLT,
    parameter int unsigned MEM_PORT_WIDTH = MEM_PORT_WIDTH_DFLT
) ();

    logic                        fsm_rdy;
    logic                        fsm_done;
    logic [COLS*WORD_SIZE-1:0]   matmul_fsm_output;
    logic [COLS-1:0]             matmul_output_valid;
    logic [COLS*WORD_SIZE-1:0]   proxy_output_bus;
    logic [COLS-1:0]             proxy_out_valid_bus;
    logic                        stall;
    logic                        wr_output_rdy;
    logic                        wr_output_done;
    logic [31:0]                 mem_addr;
    logic                        mem_wr_en;
    logic [MEM_PORT_WIDTH-1:0]   mem_data;

    modport master (
        output fsm_rdy, fsm_done, matmul_fsm_output, matmul_output_valid,
               proxy_output_bus, proxy_out_valid_bus,
        input  stall, wr_output_rdy, wr_output_done, mem_addr, mem_wr_en, mem_data
    );

    modport slave (
        input  fsm_rdy, fsm_done, matmul_fsm_output, matmul_output_valid,
               proxy_output_bus, proxy_out_valid_bus,
        output stall, wr_output_rdy, wr_output_done, mem_addr, mem_wr_en, mem_data
    );

endinterface

// File: rtl/out_col_capture.sv
// One result column: ROWS-deep buffer filled in arrival order, proxy word wins over main.
module out_col_capture #(
    parameter int unsigned ROWS      = 4,
    parameter int unsigned WORD_SIZE = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clear,
    input  logic                             enable,
    input  logic [WORD_SIZE-1:0]             main_word,
    input  logic                             main_valid,
    input  logic [WORD_SIZE-1:0]             proxy_word,
    input  logic                             proxy_valid,
    output logic [ROWS-1:0][WORD_SIZE-1:0]   rows
);

    localparam int unsigned CNT_W = $clog2(ROWS + 1);
    localparam int unsigned IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     base_cnt;
    logic [WORD_SIZE-1:0] sel_word;
    logic                 do_store;

    // A clear in the same cycle as the first valid still lets that word land in row 0.
    always_comb begin
        base_cnt = clear ? '0 : cnt;
        sel_word = proxy_valid ? proxy_word : main_word;
        do_store = enable && (proxy_valid || main_valid) && (base_cnt < CNT_W'(ROWS));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            rows <= '0;
        end else begin
            if (clear) begin
                cnt  <= '0;
                rows <= '0;
            end
            if (do_store) begin
                rows[IDX_W'(base_cnt)] <= sel_word;
                cnt                    <= base_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/matmul_out_ctrl.sv
// Output collection stage: gathers per-column results, then drains them row by row to RAM.
module matmul_out_ctrl
    import matmul_pkg::*;
#(
    parameter int unsigned ROWS               = ROWS_DFLT,
    parameter int unsigned COLS               = COLS_DFLT,
    parameter int unsigned WORD_SIZE          = WORD_SIZE_DFLT,
    parameter int unsigned MEM_PORT_WIDTH     = MEM_PORT_WIDTH_DFLT,
    parameter int unsigned MEM_ACCESS_LATENCY = MEM_ACCESS_LATENCY_DFLT,
    parameter int unsigned OUT_BASE_ADDR      = 0
) (
    input  logic              clk,
    input  logic              rst,
    matmul_out_ctrl_if.slave  bus
);

    localparam int unsigned ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned WAIT_W    = (MEM_ACCESS_LATENCY > 1) ? $clog2(MEM_ACCESS_LATENCY) : 1;
    localparam int unsigned WAIT_INIT = (MEM_ACCESS_LATENCY > 1) ? MEM_ACCESS_LATENCY - 2 : 0;
    localparam int unsigned ROW_BITS  = COLS * WORD_SIZE;

    state_t                         state, state_d;
    logic [ROW_W-1:0]               row, row_d;
    logic [WAIT_W-1:0]              wait_cnt, wait_d;
    logic                           any_valid;
    logic                           last_row;
    logic                           cap_clear;
    logic                           cap_en;
    logic [ROWS-1:0][WORD_SIZE-1:0] col_rows [COLS];
    logic [ROW_BITS-1:0]            row_word;

    assign any_valid = (|bus.matmul_output_valid) || (|bus.proxy_out_valid_bus);
    assign last_row  = (row == ROW_W'(ROWS - 1));
    assign cap_clear = (state == IDLE) && bus.fsm_rdy;
    assign cap_en    = (state == IDLE) || (state == COLLECT);

    for (genvar c = 0; c < COLS; c++) begin : g_col
        out_col_capture #(
            .ROWS      (ROWS),
            .WORD_SIZE (WORD_SIZE)
        ) u_cap (
            .clk         (clk),
            .rst         (rst),
            .clear       (cap_clear),
            .enable      (cap_en),
            .main_word   (bus.matmul_fsm_output[c*WORD_SIZE +: WORD_SIZE]),
            .main_valid  (bus.matmul_output_valid[c]),
            .proxy_word  (bus.proxy_output_bus[c*WORD_SIZE +: WORD_SIZE]),
            .proxy_valid (bus.proxy_out_valid_bus[c]),
            .rows        (col_rows[c])
        );
    end

    // Next state; row/wait counters track the row whose write is about to be shown.
    always_comb begin
        state_d = state;
        row_d   = row;
        wait_d  = wait_cnt;
        case (state)
            IDLE: begin
                if (bus.fsm_done) begin
                    state_d = WRITE;
                    row_d   = '0;
                end else if (any_valid) begin
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (bus.fsm_done) begin
                    state_d = WRITE;
                    row_d   = '0;
                end
            end
            WRITE: begin
                if (MEM_ACCESS_LATENCY > 1) begin
                    state_d = WAIT;
                    wait_d  = WAIT_W'(WAIT_INIT);
                end else if (last_row) begin
                    state_d = DONE;
                end else begin
                    row_d   = row + ROW_W'(1);
                end
            end
            WAIT: begin
                if (wait_cnt != '0) begin
                    wait_d  = wait_cnt - WAIT_W'(1);
                end else if (last_row) begin
                    state_d = DONE;
                end else begin
                    state_d = WRITE;
                    row_d   = row + ROW_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Column 0 lands in the LSBs of the RAM word.
    always_comb begin
        row_word = '0;
        for (int c = 0; c < COLS; c++) begin
            row_word[c*WORD_SIZE +: WORD_SIZE] = col_rows[c][row_d];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= IDLE;
            row                <= '0;
            wait_cnt           <= '0;
            bus.stall          <= 1'b0;
            bus.wr_output_rdy  <= 1'b0;
            bus.wr_output_done <= 1'b0;
            bus.mem_wr_en      <= 1'b0;
            bus.mem_addr       <= '0;
            bus.mem_data       <= '0;
        end else begin
            state              <= state_d;
            row                <= row_d;
            wait_cnt           <= wait_d;
            bus.stall          <= (state_d == WRITE) || (state_d == WAIT);
            bus.wr_output_rdy  <= (state_d == WRITE) || (state_d == WAIT);
            bus.wr_output_done <= (state_d == DONE);
            bus.mem_wr_en      <= (state_d == WRITE);
            if (state_d == WRITE) begin
                bus.mem_addr <= 32'(OUT_BASE_ADDR) + 32'(row_d);
                bus.mem_data <= MEM_PORT_WIDTH'(row_word);
            end
        end
    end

endmodule

// File: tb/tb_matmul_out_ctrl.sv
// Directed bench for matmul_out_ctrl: latency-1 and latency-3 instances share one stimulus source.
module tb_matmul_out_ctrl;
    import matmul_pkg::*;

    logic        clk;
    logic        rst;
    logic        sel;
    logic        rdy;
    logic        done;
    logic [63:0] main_w;
    logic [63:0] prox_w;
    logic [3:0]  main_v;
    logic [3:0]  prox_v;
    logic [63:0] exp_rows [4];

    int n_cmp;
    int n_mis;

    matmul_out_ctrl_if #(.COLS(4), .WORD_SIZE(16), .MEM_PORT_WIDTH(64)) bus1 ();
    matmul_out_ctrl_if #(.COLS(4), .WORD_SIZE(16), .MEM_PORT_WIDTH(64)) bus3 ();

    matmul_out_ctrl #(
        .ROWS(4), .COLS(4), .WORD_SIZE(16), .MEM_PORT_WIDTH(64),
        .MEM_ACCESS_LATENCY(1), .OUT_BASE_ADDR(0)
    ) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    matmul_out_ctrl #(
        .ROWS(4), .COLS(4), .WORD_SIZE(16), .MEM_PORT_WIDTH(64),
        .MEM_ACCESS_LATENCY(3), .OUT_BASE_ADDR(0)
    ) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

    // Only the selected instance sees done/valid pulses; the other idles with fsm_rdy high.
    assign bus1.fsm_rdy             = rdy;
    assign bus1.fsm_done            = done && !sel;
    assign bus1.matmul_fsm_output   = main_w;
    assign bus1.matmul_output_valid = main_v & {4{!sel}};
    assign bus1.proxy_output_bus    = prox_w;
    assign bus1.proxy_out_valid_bus = prox_v & {4{!sel}};
    assign bus3.fsm_rdy             = rdy;
    assign bus3.fsm_done            = done && sel;
    assign bus3.matmul_fsm_output   = main_w;
    assign bus3.matmul_output_valid = main_v & {4{sel}};
    assign bus3.proxy_output_bus    = prox_w;
    assign bus3.proxy_out_valid_bus = prox_v & {4{sel}};

    logic        obs_we, obs_stall, obs_rdy, obs_done;
    logic [31:0] obs_addr;
    logic [63:0] obs_data;
    assign obs_we    = sel ? bus3.mem_wr_en      : bus1.mem_wr_en;
    assign obs_stall = sel ? bus3.stall          : bus1.stall;
    assign obs_rdy   = sel ? bus3.wr_output_rdy  : bus1.wr_output_rdy;
    assign obs_done  = sel ? bus3.wr_output_done : bus1.wr_output_done;
    assign obs_addr  = sel ? bus3.mem_addr       : bus1.mem_addr;
    assign obs_data  = sel ? bus3.mem_data       : bus1.mem_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_we"},    64'(obs_we),    64'd0);
        check_val({tag, "_stall"}, 64'(obs_stall), 64'd0);
        check_val({tag, "_rdy"},   64'(obs_rdy),   64'd0);
        check_val({tag, "_done"},  64'(obs_done),  64'd0);
        check_val({tag, "_addr"},  64'(obs_addr),  64'd0);
        check_val({tag, "_data"},  obs_data,       64'd0);
    endtask

    // Column c receives 10*r+c for row r at cycle r+c, as the array skews its outputs.
    task automatic stream_skewed();
        for (int t = 0; t < 7; t++) begin
            @(negedge clk);
            rdy = 1'b0;
            for (int c = 0; c < 4; c++) begin
                if (t - c >= 0 && t - c < 4) begin
                    main_v[c]           = 1'b1;
                    main_w[c*16 +: 16]  = 16'(10 * (t - c) + c);
                end else begin
                    main_v[c] = 1'b0;
                end
            end
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                exp_rows[r][c*16 +: 16] = 16'(10 * r + c);
    endtask

    // Pulse fsm_done, then check every output cycle by cycle against the drain schedule.
    task automatic run_drain(input int lat, input string tag);
        int total;
        total = 4 * lat;
        @(negedge clk);
        main_v = '0;
        prox_v = '0;
        done   = 1'b1;
        rdy    = 1'b1;
        for (int k = 0; k < 20; k++) begin
            logic exp_we;
            @(negedge clk);
            done   = 1'b0;
            exp_we = (k < total) && (k % lat == 0);
            check_val($sformatf("%s_we_k%0d", tag, k),    64'(obs_we),    64'(exp_we));
            check_val($sformatf("%s_stall_k%0d", tag, k), 64'(obs_stall), 64'(k < total));
            check_val($sformatf("%s_rdy_k%0d", tag, k),   64'(obs_rdy),   64'(k < total));
            check_val($sformatf("%s_done_k%0d", tag, k),  64'(obs_done),  64'(k == total));
            if (exp_we) begin
                check_val($sformatf("%s_addr_r%0d", tag, k / lat), 64'(obs_addr), 64'(k / lat));
                check_val($sformatf("%s_data_r%0d", tag, k / lat), obs_data, exp_rows[k / lat]);
            end
        end
    endtask

    initial begin
        word_t w;
        n_cmp  = 0;
        n_mis  = 0;
        rst    = 1'b0;
        sel    = 1'b0;
        rdy    = 1'b1;
        done   = 1'b0;
        main_w = '0;
        prox_w = '0;
        main_v = '0;
        prox_v = '0;

        #12;
        check_idle_outputs("reset_lat1");
        sel = 1'b1;
        #1;
        check_idle_outputs("reset_lat3");
        sel = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Reset while row 1 is being written.
        stream_skewed();
        @(negedge clk);
        main_v = '0;
        done   = 1'b1;
        rdy    = 1'b1;
        @(negedge clk);
        done = 1'b0;
        @(negedge clk);
        check_val("abort_pre_we",   64'(obs_we),   64'd1);
        check_val("abort_pre_addr", 64'(obs_addr), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check_val("abort_we",    64'(obs_we),    64'd0);
        check_val("abort_stall", 64'(obs_stall), 64'd0);
        check_val("abort_rdy",   64'(obs_rdy),   64'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_val($sformatf("abort_nodone_k%0d", k), 64'(obs_done), 64'd0);
            check_val($sformatf("abort_nowe_k%0d", k),   64'(obs_we),   64'd0);
        end

        // fsm_done straight from IDLE drains an all-zero matrix.
        for (int r = 0; r < 4; r++) exp_rows[r] = '0;
        run_drain(1, "idle_done");

        stream_skewed();
        run_drain(1, "basic");

        // Proxy overrides main on column 1 row 0; proxy-only word on column 3 row 2.
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            rdy    = 1'b0;
            main_v = 4'hF;
            prox_v = '0;
            for (int c = 0; c < 4; c++) begin
                w                    = word_t'(16'h0100 * r + c);
                main_w[c*16 +: 16]   = w;
                exp_rows[r][c*16 +: 16] = w;
            end
            if (r == 0) begin
                main_w[16 +: 16]   = 16'h1111;
                prox_w[16 +: 16]   = 16'h2222;
                prox_v[1]          = 1'b1;
                exp_rows[0][16 +: 16] = 16'h2222;
            end
            if (r == 2) begin
                main_v[3]          = 1'b0;
                prox_w[48 +: 16]   = 16'h3333;
                prox_v[3]          = 1'b1;
                exp_rows[2][48 +: 16] = 16'h3333;
            end
        end
        run_drain(1, "proxy");

        // Fifth word on columns 0..2 is dropped; column 3 only ever gets two words.
        for (int r = 0; r < 5; r++) begin
            @(negedge clk);
            rdy = 1'b0;
            for (int c = 0; c < 4; c++) begin
                w                  = word_t'(16'h0A00 + 16 * r + c);
                main_w[c*16 +: 16] = w;
                main_v[c]          = (c < 3) || (r < 2);
                if (r < 4)
                    exp_rows[r][c*16 +: 16] = ((c < 3) || (r < 2)) ? w : 16'h0000;
            end
        end
        run_drain(1, "ovf_unf");

        sel = 1'b1;
        stream_skewed();
        run_drain(3, "lat3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
